mmio_io_controller: RTL

- Memory-mapped I/O stage on the data-memory side of the single-cycle core. It sits beside the data memory and consumes the same ALU address, store data and write enable.
- Owns the board peripherals: HEX display register, LEDR register, KEY and SW inputs.
- Synchronises and debounces KEY and SW, latches sticky key-press flags, and returns combinational read data plus a hit flag. The load-data mux uses the hit flag to select between data memory and I/O.

---
 rtl/io_pkg.sv | 28 ++
 rtl/io_debouncer.sv | 63 ++++++
 rtl/mmio_io_controller.sv | 108 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped board I/O block: register addresses,
// peripheral widths and the KEY read-word layout.
package io_pkg;

  localparam logic [31:0] IO_ADDR_HEX  = 32'hF000_0000;
  localparam logic [31:0] IO_ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] IO_ADDR_KEY  = 32'hF000_0010;
  localparam logic [31:0] IO_ADDR_SW   = 32'hF000_0014;

  localparam int KEY_BITS  = 4;
  localparam int SW_BITS   = 10;
  localparam int HEX_BITS  = 16;
  localparam int LEDR_BITS = 10;
  localparam int CNT_BITS  = 20;

  // KEY read word: {flags, stable} in the low byte
  localparam int KEY_STABLE_LSB = 0;
  localparam int KEY_FLAGS_LSB  = 4;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_HEX,
    SEL_LEDR,
    SEL_KEY,
    SEL_SW
  } io_sel_e;

endpackage

// File: rtl/io_debouncer.sv
// Two-flop synchroniser plus optional stable-count debouncer for one input group.
// Debounce counting is built only when IO_DEBOUNCE_EN is defined.
module io_debouncer
  import io_pkg::*;
#(
  parameter int                  WIDTH           = 1,
  parameter logic [CNT_BITS-1:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [WIDTH-1:0]    RESET_VALUE     = '0,
  parameter bit                  ACTIVE_LOW      = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);

  if (DEBOUNCE_CYCLES == '0) begin : g_bad_cycles
    $error("io_debouncer: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] synced;

  // NOTE: non-blocking assignments keep the two synchroniser stages distinct flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= RESET_VALUE;
      sync_q2 <= RESET_VALUE;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  assign synced = ACTIVE_LOW ? ~sync_q2 : sync_q2;

`ifdef IO_DEBOUNCE_EN
  logic [CNT_BITS-1:0] cnt;
  logic [WIDTH-1:0]    stable_q;

  // Counter measures time away from the accepted value, not since the last sample change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      stable_q <= '0;
    end else if (synced == stable_q) begin
      cnt <= '0;
    end else if (cnt == DEBOUNCE_CYCLES - 1'b1) begin
      stable_q <= synced;
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stable = stable_q;
`else
  // The second synchroniser stage doubles as the stable register.
  assign stable = synced;
`endif

endmodule

// File: rtl/mmio_io_controller.sv
// Memory-mapped board I/O beside data memory: HEX/LEDR registers, KEY/SW inputs,
// sticky key-press flags. Define IO_DEBOUNCE_EN to enable input debouncing.
module mmio_io_controller
  import io_pkg::*;
#(
  parameter int                  DBITS           = 32,
  parameter logic [DBITS-1:0]    ADDR_HEX        = DBITS'(IO_ADDR_HEX),
  parameter logic [DBITS-1:0]    ADDR_LEDR       = DBITS'(IO_ADDR_LEDR),
  parameter logic [DBITS-1:0]    ADDR_KEY        = DBITS'(IO_ADDR_KEY),
  parameter logic [DBITS-1:0]    ADDR_SW         = DBITS'(IO_ADDR_SW),
  parameter logic [CNT_BITS-1:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DBITS-1:0]     addr,
  input  logic                 wr_en,
  input  logic [DBITS-1:0]     wdata,
  input  logic [KEY_BITS-1:0]  key,
  input  logic [SW_BITS-1:0]   sw,
  output logic                 io_hit,
  output logic [DBITS-1:0]     io_rdata,
  output logic [HEX_BITS-1:0]  hex_out,
  output logic [LEDR_BITS-1:0] ledr_out
);

  io_sel_e             sel;
  logic [KEY_BITS-1:0] key_stable;
  logic [KEY_BITS-1:0] key_prev;
  logic [KEY_BITS-1:0] flags;
  logic [KEY_BITS-1:0] flag_set;
  logic [KEY_BITS-1:0] flag_clr;
  logic [SW_BITS-1:0]  sw_stable;
  logic                unused_wdata;

  assign unused_wdata = ^wdata[DBITS-1:HEX_BITS];

  // Keys are active-low on the board; inverted after sync so 1 = pressed.
  io_debouncer #(
    .WIDTH          (KEY_BITS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VALUE    (4'hF),
    .ACTIVE_LOW     (1'b1)
  ) u_key_db (
    .clk   (clk),
    .reset (reset),
    .din   (key),
    .stable(key_stable)
  );

  io_debouncer #(
    .WIDTH          (SW_BITS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VALUE    ('0),
    .ACTIVE_LOW     (1'b0)
  ) u_sw_db (
    .clk   (clk),
    .reset (reset),
    .din   (sw),
    .stable(sw_stable)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = SEL_NONE;
    if      (addr == ADDR_HEX)  sel = SEL_HEX;
    else if (addr == ADDR_LEDR) sel = SEL_LEDR;
    else if (addr == ADDR_KEY)  sel = SEL_KEY;
    else if (addr == ADDR_SW)   sel = SEL_SW;
  end

  assign io_hit = (sel != SEL_NONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_out  <= '0;
      ledr_out <= '0;
    end else if (wr_en) begin
      if (sel == SEL_HEX)  hex_out  <= wdata[HEX_BITS-1:0];
      if (sel == SEL_LEDR) ledr_out <= wdata[LEDR_BITS-1:0];
    end
  end

  assign flag_set = key_stable & ~key_prev;
  assign flag_clr = (wr_en && sel == SEL_KEY) ? wdata[KEY_FLAGS_LSB +: KEY_BITS] : '0;

  // Set is OR-ed in after the clear so a same-cycle press is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_prev <= '0;
      flags    <= '0;
    end else begin
      key_prev <= key_stable;
      flags    <= (flags & ~flag_clr) | flag_set;
    end
  end

  always_comb begin
    io_rdata = '0;
    case (sel)
      SEL_HEX:  io_rdata = DBITS'(hex_out);
      SEL_LEDR: io_rdata = DBITS'(ledr_out);
      SEL_KEY:  io_rdata = DBITS'({flags, key_stable});
      SEL_SW:   io_rdata = DBITS'(sw_stable);
      default:  io_rdata = '0;
    endcase
  end

endmodule
